// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared shift-add multiplier definitions: state encoding and widths
package mult_pkg;

  localparam int N_DEF = 4;
  localparam int ACC_W = 2 * N_DEF + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mult_shift_cnt.sv
// rtl/mult_shift_cnt.sv - shift counter with load-zero, increment and terminal-count output
module mult_shift_cnt #(
  parameter int N = 4,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [CW-1:0] o_cnt,
  output logic          o_tc
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == CW'(N - 1));

endmodule

// File: rtl/mult_ctrl.sv
// rtl/mult_ctrl.sv - shift-add multiplier control FSM producing Load/Ad/Sh strobes for the accumulator
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int N = N_DEF,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic St,
  input  logic M,
  output logic Load,
  output logic Ad,
  output logic Sh,
  output logic Busy,
  output logic Done
);

  state_t        r_state;
  state_t        w_next;
  logic          w_load;
  logic          w_ad;
  logic          w_sh;
  logic          w_clr;
  logic          w_inc;
  logic          w_tc;
  logic [CW-1:0] w_cnt;

  mult_shift_cnt #(.N(N)) u_cnt (
    .i_clk   (Clk),
    .i_rst_n (Rst_n),
    .i_clr   (w_clr),
    .i_inc   (w_inc),
    .o_cnt   (w_cnt),
    .o_tc    (w_tc)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The counter holds at N-1 on the final shift so it never wraps before IDLE clears it.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_ad   = 1'b0;
    w_sh   = 1'b0;
    w_clr  = 1'b0;
    w_inc  = 1'b0;
    case (r_state)
      IDLE: begin
        w_load = St;
        if (St) begin
          w_next = CHECK;
          w_clr  = 1'b1;
        end
      end
      CHECK: begin
        if (M) begin
          w_ad   = 1'b1;
          w_next = SHIFT;
        end else begin
          w_sh  = 1'b1;
          w_inc = !w_tc;
          if (w_tc) begin
            w_next = DONE;
          end
        end
      end
      SHIFT: begin
        w_sh   = 1'b1;
        w_inc  = !w_tc;
        w_next = w_tc ? DONE : CHECK;
      end
      DONE: begin
        if (!St) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Gating with Rst_n keeps the Mealy Load quiet while reset is held with St high.
  assign Load = Rst_n & w_load;
  assign Ad   = Rst_n & w_ad;
  assign Sh   = Rst_n & w_sh;
  assign Busy = Rst_n & ((r_state == CHECK) || (r_state == SHIFT));
  assign Done = Rst_n & (r_state == DONE);

  logic w_unused;
  assign w_unused = ^w_cnt;

endmodule

// File: tb/tb_mult_ctrl.sv
// tb/tb_mult_ctrl.sv - scoreboard bench for mult_ctrl with a paired 9-bit accumulator model
module tb_mult_ctrl;
  import mult_pkg::*;

  logic Clk;
  logic Rst_n;
  logic St;
  logic M;
  logic Load;
  logic Ad;
  logic Sh;
  logic Busy;
  logic Done;

  logic [ACC_W-1:0] acc;
  logic [3:0]       mplier;
  logic [3:0]       mcand;
  logic [4:0]       exp_q[$];
  int               total;
  int               bad;
  int               sh_seen;

  mult_ctrl #(.N(4)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .St    (St),
    .M     (M),
    .Load  (Load),
    .Ad    (Ad),
    .Sh    (Sh),
    .Busy  (Busy),
    .Done  (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (Load) begin
      acc <= {5'b0, mplier};
    end else if (Ad) begin
      acc[8:4] <= {1'b0, acc[7:4]} + {1'b0, mcand};
    end else if (Sh) begin
      acc <= acc >> 1;
    end
  end

  assign M = acc[0];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  // L=Load, A=Ad, S=Sh, D=Done rising; codes are {Load,Ad,Sh,Busy,Done}
  task automatic push_seq(input string s);
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "L": exp_q.push_back(5'b10000);
        "A": exp_q.push_back(5'b01010);
        "S": exp_q.push_back(5'b00110);
        "D": exp_q.push_back(5'b00001);
        default: exp_q.push_back(5'b11111);
      endcase
    end
  endtask

  initial begin
    logic       pd;
    logic [4:0] got;
    logic [4:0] req;
    pd = 1'b0;
    forever begin
      @(negedge Clk);
      if (Rst_n) begin
        got = {Load, Ad, Sh, Busy, Done};
        if (Sh) sh_seen++;
        if (Load || Ad || Sh || (Done && !pd)) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL strobe: got %b required nothing (queue empty)", got);
          end else begin
            req = exp_q.pop_front();
            if (got !== req) begin
              bad++;
              $display("FAIL strobe: got %b required %b", got, req);
            end
          end
        end
        pd = Done;
      end else begin
        pd = 1'b0;
      end
    end
  end

  task automatic run_mult(input logic [3:0] mp, input string seq, input int lat,
                          input logic [8:0] prod, input bit hold);
    int cyc;
    int s0;
    mplier = mp;
    push_seq(seq);
    s0 = sh_seen;
    @(posedge Clk);
    #2 St = 1'b1;
    @(negedge Clk);
    cyc = 1;
    if (!hold) begin
      @(posedge Clk);
      #2 St = 1'b0;
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (Done) break;
      cyc++;
    end
    chk("done_seen", 32'(Done), 32'd1);
    chk("latency", 32'(cyc), 32'(lat));
    chk("product", 32'(acc), 32'(prod));
    chk("sh_count", 32'(sh_seen - s0), 32'd4);
    if (!hold) begin
      @(negedge Clk);
      chk("done_drop", 32'(Done), 32'd0);
      chk("idle_busy", 32'(Busy), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total   = 0;
    bad     = 0;
    sh_seen = 0;
    Rst_n   = 1'b0;
    St      = 1'b1;
    mplier  = 4'b0000;
    mcand   = 4'b1011;

    repeat (3) @(negedge Clk);
    chk("reset_outs", 32'({Load, Ad, Sh, Busy, Done}), 32'd0);
    @(posedge Clk);
    #2 Rst_n = 1'b1;
    #1 chk("load_after_reset", 32'(Load), 32'd1);
    chk("busy_after_reset", 32'(Busy), 32'd0);
    #1 St = 1'b0;
    @(negedge Clk);
    chk("idle_quiet", 32'({Load, Ad, Sh, Busy, Done}), 32'd0);

    run_mult(4'b1101, "LASSASASD", 8, 9'h08F, 1'b0);
    run_mult(4'b0000, "LSSSSD", 5, 9'h000, 1'b0);
    run_mult(4'b1111, "LASASASASD", 9, 9'h0A5, 1'b0);

    run_mult(4'b0101, "LASSASSD", 7, 9'h037, 1'b1);
    repeat (5) begin
      @(negedge Clk);
      chk("held_done", 32'(Done), 32'd1);
      chk("held_busy", 32'(Busy), 32'd0);
    end
    @(posedge Clk);
    #2 St = 1'b0;
    @(negedge Clk);
    chk("held_done_last", 32'(Done), 32'd1);
    @(negedge Clk);
    chk("held_release", 32'({Load, Done}), 32'd0);

    mplier = 4'b1111;
    push_seq("LASA");
    @(posedge Clk);
    #2 St = 1'b1;
    @(posedge Clk);
    #2 St = 1'b0;
    repeat (3) @(posedge Clk);
    #2 Rst_n = 1'b0;
    #1 chk("reset_mid", 32'({Load, Ad, Sh, Busy, Done}), 32'd0);
    @(negedge Clk);
    chk("reset_mid_hold", 32'({Load, Ad, Sh, Busy, Done}), 32'd0);
    @(posedge Clk);
    #2 Rst_n = 1'b1;
    @(negedge Clk);
    chk("after_mid_reset", 32'({Load, Ad, Sh, Busy, Done}), 32'd0);

    run_mult(4'b1101, "LASSASASD", 8, 9'h08F, 1'b0);

    repeat (2) @(negedge Clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_ctrl.md
Name: mult_ctrl

Overview:
- Control FSM for the shift-add multiplier. It drives the accumulator's Load, Ad and Sh strobes and reads back the accumulator LSB (multiplier bit under test).
- Sits beside the 9-bit accumulator inside the multiplier: accumulator is the strobe consumer, this block is the strobe producer.
- Sequences one N-bit by N-bit multiply per start request and flags completion to the datapath/CPU stall logic.

Parameters:
- N, 4, multiplier/multiplicand width; the paired accumulator is 2N+1 bits wide.
- CW, $clog2(N), shift-counter width (derived, not overridden).

Ports:
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous active-low reset
- St  in  1  start request; level-sensitive
- M  in  1  accumulator bit 0 (current multiplier bit)
- Load  out  1  load accumulator with multiplier (low half), clear high half
- Ad  out  1  add multiplicand into accumulator high part
- Sh  out  1  shift accumulator right one bit
- Busy  out  1  multiply in progress (state != IDLE and != DONE)
- Done  out  1  product valid in accumulator

Behaviour:
- Reset (async, Rst_n=0): state=IDLE, cnt=0. Load, Ad, Sh, Busy and Done are all 0 while reset is held. Reset mid-multiply aborts immediately, with no further strobes.
- States: IDLE, CHECK, SHIFT, DONE. State and cnt are registered. Load/Ad/Sh are decoded combinationally from state, St and M (Mealy).
- IDLE:
  - Load = St.
  - If St=1 at the clock edge, go to CHECK with cnt<=0. Otherwise stay in IDLE.
- CHECK (M sampled only here):
  - M=1: Ad=1; next state SHIFT; cnt unchanged.
  - M=0: Sh=1; cnt<=cnt+1. If cnt==N-1, go to DONE, else stay in CHECK.
- SHIFT:
  - Sh=1; cnt<=cnt+1.
  - If cnt==N-1, go to DONE, else go to CHECK.
- DONE:
  - Done=1 and Busy=0.
  - Stays in DONE while St=1, which prevents auto-restart on a held start.
  - On St=0, go to IDLE. Done deasserts the cycle after St falls.
- Exclusivity: at most one of Load/Ad/Sh is high in any cycle. St is ignored in CHECK, SHIFT and DONE.
- Sh count: exactly N Sh cycles per multiply.
- Latency: 1 Load cycle + N + (number of ones in the multiplier) CHECK/SHIFT cycles, then DONE.
  - Min N+1 cycles (multiplier 0).
  - Max 2N+1 cycles (all ones).
- Counter: cnt wraps only by returning to IDLE; it never exceeds N-1 in CHECK/SHIFT.
- Unknown M (X) in CHECK is a bench error; the RTL need not guard against it.

Decomposition:
- Shared multiplier package holds:
  - state encoding constants (IDLE=2'd0, CHECK=2'd1, SHIFT=2'd2, DONE=2'd3);
  - default N=4 and derived ACC width 2N+1.
- No sub-module needed. Optionally factor the shift counter as mult_shift_cnt (load-zero, increment, terminal-count output) for reuse by a future divider controller.

Test Plan:
- Reset: hold Rst_n=0 with St=1 -> Load=Ad=Sh=Done=Busy=0; release -> IDLE, Load=1 combinationally.
- Multiplier 4'b1101 (M sequence 1,0,1,1 as bits shift in), St pulse:
  - Load for 1 cycle, then Ad,Sh,Sh,Ad,Sh,Ad,Sh (7 cycles).
  - Then Done=1.
  - Paired accumulator with multiplicand 4'b1011 ends at 9'h08F (11*13=143).
- Multiplier 0 (M=0 always) -> Load, then Sh x4, then Done. No Ad ever; total 5 cycles to DONE.
- Multiplier 4'b1111 -> Load, then Ad/Sh alternating x4 (8 cycles), then Done. Exactly 4 Sh pulses are counted.
- Held start: St stays 1 through completion -> block remains in DONE with Done=1 and no new Load. Drop St -> IDLE next cycle. Raise St -> new Load.
- Reset mid-operation: assert Rst_n=0 during the second SHIFT -> all strobes drop asynchronously. After release, block is in IDLE with cnt=0 and no Done.
